tdm_demux: RTL

TDM_DEMUX -- requirements
Module: tdm_demux

---
 rtl/tdm_demux_if.sv | 27 ++
 rtl/tdm_demux.sv | 77 +++++++
 2 files changed

// File: rtl/tdm_demux_if.sv
// rtl/tdm_demux_if.sv - serial TDM input and per-channel word outputs of the demux
interface tdm_demux_if #(
  parameter int WIDTH = 8
);
  logic             mux;
  logic             control;
  logic             in_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
  logic             a_ovr;
  logic             b_ovr;
  logic             ovr_clr;

  modport master (
    output mux, control, in_valid, a_ready, b_ready, ovr_clr,
    input  a_data, a_valid, b_data, b_valid, a_ovr, b_ovr
  );

  modport slave (
    input  mux, control, in_valid, a_ready, b_ready, ovr_clr,
    output a_data, a_valid, b_data, b_valid, a_ovr, b_ovr
  );
endinterface

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - two-channel TDM bit demultiplexer with per-channel word reassembly
module tdm_demux #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic        clk,
  input logic        rstb,
  tdm_demux_if.slave bus
);
  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Index 0 is channel A, index 1 is channel B.
  logic [CW-1:0]    cnt    [2];
  logic [WIDTH-1:0] shreg  [2];
  logic [WIDTH-1:0] word   [2];
  logic [WIDTH-1:0] data_q [2];
  logic             valid_q[2];
  logic             ovr_q  [2];
  logic [1:0]       accept;
  logic [1:0]       done;
  logic [1:0]       ready;

  always_comb begin
    accept = '0;
    done   = '0;
    ready  = {bus.b_ready, bus.a_ready};
    for (int c = 0; c < 2; c++) begin
      accept[c] = bus.in_valid && (bus.control == 1'(c));
      done[c]   = accept[c] && (cnt[c] == LAST);
      // Word as it will look once the current bit is shifted in.
      if (MSB_FIRST)
        word[c] = {shreg[c][WIDTH-2:0], bus.mux};
      else
        word[c] = {bus.mux, shreg[c][WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int c = 0; c < 2; c++) begin
        cnt[c]     <= '0;
        shreg[c]   <= '0;
        data_q[c]  <= '0;
        valid_q[c] <= 1'b0;
        ovr_q[c]   <= 1'b0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (accept[c]) begin
          shreg[c] <= word[c];
          cnt[c]   <= done[c] ? '0 : cnt[c] + 1'b1;
        end

        // Holding register frees up on the same edge it is drained.
        if (done[c] && (!valid_q[c] || ready[c])) begin
          data_q[c]  <= word[c];
          valid_q[c] <= 1'b1;
        end else if (valid_q[c] && ready[c]) begin
          valid_q[c] <= 1'b0;
        end

        if (done[c] && valid_q[c] && !ready[c])
          ovr_q[c] <= 1'b1;
        else if (bus.ovr_clr)
          ovr_q[c] <= 1'b0;
      end
    end
  end

  assign bus.a_data  = data_q[0];
  assign bus.a_valid = valid_q[0];
  assign bus.a_ovr   = ovr_q[0];
  assign bus.b_data  = data_q[1];
  assign bus.b_valid = valid_q[1];
  assign bus.b_ovr   = ovr_q[1];
endmodule
